// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection controller: phase encoding,
// {R,G,Y} lamp patterns and default phase lengths.
package traffic_pkg;

  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_YELLOW = 3'd1,
    AR1      = 3'd2,
    B_GREEN  = 3'd3,
    B_YELLOW = 3'd4,
    AR2      = 3'd5,
    WALK     = 3'd6
  } state_t;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_G = 3'b010;
  localparam logic [2:0] LAMP_Y = 3'b001;

  localparam int DEF_G_CYC    = 512;
  localparam int DEF_Y_CYC    = 64;
  localparam int DEF_AR_CYC   = 16;
  localparam int DEF_WALK_CYC = 128;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase counter: cleared on request, otherwise counts up; done flags the last
// cycle of the current phase.
module phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [W-1:0] term,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count <= '0;
    else if (clear)
      count <= '0;
    else
      count <= count + 1'b1;
  end

  assign done = (count == term);

endmodule

// File: rtl/intersection_ctrl.sv
// Two-road traffic light controller with priority pass for road A.
// Define INTERSECTION_PED_WALK_EN to build the pedestrian WALK phase.
module intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int G_CYC    = DEF_G_CYC,
  parameter int Y_CYC    = DEF_Y_CYC,
  parameter int AR_CYC   = DEF_AR_CYC,
  parameter int WALK_CYC = DEF_WALK_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pass,
  input  logic       ped_req,
  output logic [2:0] a_rgy,
  output logic [2:0] b_rgy,
  output logic       walk,
  output logic [2:0] phase
);

  localparam int MAX_LEN = max_int(max_int(G_CYC, Y_CYC), max_int(AR_CYC, WALK_CYC));
  localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_t        state;
  state_t        state_next;
  logic          restart;
  logic          clear;
  logic          done;
  logic [CW-1:0] term;
  logic          pass_pend;
  logic          walk_go;

`ifdef INTERSECTION_PED_WALK_EN
  logic ped_pend;
  logic walk_to_b;
  assign walk_go = ped_pend && !pass_pend;
`else
  logic unused_ped;
  assign unused_ped = ped_req;
  assign walk_go    = 1'b0;
`endif

  always_comb begin
    term = CW'(G_CYC - 1);
    case (state)
      A_YELLOW, B_YELLOW: term = CW'(Y_CYC - 1);
      AR1, AR2:           term = CW'(AR_CYC - 1);
      WALK:               term = CW'(WALK_CYC - 1);
      default:            term = CW'(G_CYC - 1);
    endcase
  end

  assign clear = restart || (state_next != state);

  phase_timer #(.W(CW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .term  (term),
    .done  (done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= A_GREEN;
      pass_pend <= 1'b0;
`ifdef INTERSECTION_PED_WALK_EN
      ped_pend  <= 1'b0;
      walk_to_b <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (state_next == A_GREEN && state != A_GREEN)
        pass_pend <= 1'b0;
      else if (pass && state != A_GREEN)
        pass_pend <= 1'b1;
`ifdef INTERSECTION_PED_WALK_EN
      // A press landing in the WALK entry cycle must survive for the next walk.
      if (ped_req)
        ped_pend <= 1'b1;
      else if (state_next == WALK && state != WALK)
        ped_pend <= 1'b0;
      if (state == AR1 && state_next == WALK)
        walk_to_b <= 1'b1;
      else if (state == AR2 && state_next == WALK)
        walk_to_b <= 1'b0;
`endif
    end
  end

  always_comb begin
    state_next = state;
    restart    = 1'b0;
    case (state)
      A_GREEN: begin
        if (pass)
          restart = 1'b1;
        else if (done)
          state_next = A_YELLOW;
      end
      A_YELLOW: if (done) state_next = AR1;
      AR1:      if (done) state_next = walk_go ? WALK : B_GREEN;
      B_GREEN:  if (done || pass || pass_pend) state_next = B_YELLOW;
      B_YELLOW: if (done) state_next = AR2;
      AR2:      if (done) state_next = walk_go ? WALK : A_GREEN;
`ifdef INTERSECTION_PED_WALK_EN
      WALK:     if (done) state_next = walk_to_b ? B_GREEN : A_GREEN;
`endif
      default:  state_next = A_GREEN;
    endcase
  end

  always_comb begin
    a_rgy = LAMP_R;
    b_rgy = LAMP_R;
    walk  = 1'b0;
    case (state)
      A_GREEN:  a_rgy = LAMP_G;
      A_YELLOW: a_rgy = LAMP_Y;
      B_GREEN:  b_rgy = LAMP_G;
      B_YELLOW: b_rgy = LAMP_Y;
`ifdef INTERSECTION_PED_WALK_EN
      WALK:     walk  = 1'b1;
`endif
      default: ;
    endcase
  end

  assign phase = state;

endmodule

// File: doc/intersection_ctrl.md
INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

Interface
REQ-001 SHALL have parameter G_CYC, default 512, green phase length in cycles (>=1).
REQ-002 SHALL have parameter Y_CYC, default 64, yellow phase length in cycles (>=1).
REQ-003 SHALL have parameter AR_CYC, default 16, all-red clearance length in cycles (>=1).
REQ-004 SHALL have parameter WALK_CYC, default 128, pedestrian walk length in cycles (>=1).
REQ-005 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port pass  input  1  one-cycle priority pulse requesting green for road A.
REQ-008 SHALL have port ped_req  input  1  one-cycle pedestrian button pulse.
REQ-009 SHALL have port a_rgy  output  3  road A lamps {R,G,Y}, exactly one bit high.
REQ-010 SHALL have port b_rgy  output  3  road B lamps {R,G,Y}, exactly one bit high.
REQ-011 SHALL have port walk  output  1  pedestrian walk lamp.
REQ-012 SHALL have port phase  output  3  current state encoding (debug).

Function
REQ-013 SHALL implement states A_GREEN(0), A_YELLOW(1), AR1(2), B_GREEN(3), B_YELLOW(4), AR2(5), WALK(6).
REQ-014 SHALL keep a phase counter cleared on every state entry; a state exits when counter == <len>-1, so each state lasts exactly its length.
REQ-015 SHALL sequence A_GREEN -> A_YELLOW -> AR1 -> B_GREEN -> B_YELLOW -> AR2 -> A_GREEN absent requests.
REQ-016 SHALL decode outputs as Moore functions of state: A_GREEN a=010 b=100; A_YELLOW a=001 b=100; B_GREEN a=100 b=010; B_YELLOW a=100 b=001; AR1/AR2/WALK a=100 b=100; walk=1 only in WALK.
REQ-017 SHALL set ped_pend on ped_req=1; clear on WALK entry; ped_req in the entry cycle keeps ped_pend set.
REQ-018 SHALL, at AR1/AR2 exit with ped_pend=1 and pass_pend=0, enter WALK, recording next green (B after AR1, A after AR2); WALK exits to that green.
REQ-019 SHALL, on pass=1 in A_GREEN, restart the counter at 0 (green extended); no pending flag set.
REQ-020 SHALL, on pass=1 in any other state, set pass_pend; cleared on A_GREEN entry.
REQ-021 SHALL, in B_GREEN with pass_pend=1, exit to B_YELLOW at end of the current cycle (B green truncated, minimum 1 cycle).
REQ-022 SHALL never drive green or yellow on both roads simultaneously; every green-to-green change passes through yellow and all-red.
REQ-023 SHALL size counter to clog2 of largest length; no wrap within a state.

Reset
REQ-024 SHALL, while rst=0, force state A_GREEN, counter 0, ped_pend 0, pass_pend 0, a_rgy=010, b_rgy=100, walk=0, phase=0.
REQ-025 SHALL, on reset deassertion mid-phase, restart at A_GREEN cycle 0; pending requests lost.

Configuration
REQ-026 SHALL, with macro INTERSECTION_PED_WALK_EN defined, implement WALK state, ped_pend and walk per REQ-017/018.
REQ-027 SHALL, without INTERSECTION_PED_WALK_EN, omit WALK and ped_pend, ignore ped_req, tie walk to 0.

Structure
REQ-028 SHALL place state enumeration, {R,G,Y} lamp constants and default length constants in shared package traffic_pkg.
REQ-029 SHALL instantiate one sub-module phase_timer (load/clear, terminal-count compare) for the phase counter; FSM remains in intersection_ctrl.

Verification (G_CYC=8, Y_CYC=3, AR_CYC=2, WALK_CYC=4, cycle 0 = first edge after reset release)
REQ-030 SHALL check free run: A_GREEN cycles 0-7, A_YELLOW 8-10, AR1 11-12, B_GREEN 13-20, B_YELLOW 21-23, AR2 24-25, A_GREEN again at 26; period 26.
REQ-031 SHALL check ped_req at cycle 5: WALK cycles 13-16 with walk=1, both roads 100, then B_GREEN 17-24.
REQ-032 SHALL check pass at cycle 15 (B_GREEN): B_YELLOW 16-18, AR2 19-20, A_GREEN from 21.
REQ-033 SHALL check pass at cycle 6 (A_GREEN): A_GREEN extends through cycle 14, A_YELLOW from 15.
REQ-034 SHALL check rst low at cycle 22 for one cycle: outputs a=010 b=100 immediately (async), A_GREEN restarts from cycle 0 after release.
REQ-035 SHALL check, without INTERSECTION_PED_WALK_EN, ped_req at cycle 5 leaves REQ-030 timing unchanged and walk=0.
